// File: rtl/calc_pkg.sv
// Shared definitions for the calculator display path: converter FSM states,
// the blank-digit code and the digit-count width helper.
package calc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_FINISH,
    ST_HOLD
  } state_e;

  // Nibble code driven for blanked (leading-zero) digit positions.
  localparam logic [3:0] DIGIT_BLANK = 4'hF;

  // Bits needed to hold a digit count in the range 0..digits.
  function automatic int unsigned calc_lw(input int unsigned digits);
    return $clog2(digits + 1);
  endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble step on a packed BCD accumulator.
// Ports:
//   acc_i   : current accumulator, digit i at [4i+3:4i]
//   bit_i   : binary bit shifted into digit 0
//   acc_o   : accumulator after add-3 correction and left shift
//   carry_o : bit shifted out of the most significant digit
module bcd_dabble_step #(
  parameter int unsigned DIGITS = 7
) (
  input  logic [4*DIGITS-1:0] acc_i,
  input  logic                bit_i,
  output logic [4*DIGITS-1:0] acc_o,
  output logic                carry_o
);

  logic [4*DIGITS-1:0] adj_c;

  // Digits of 5 or more become 8 or more, so the shift carries decimally.
  always_comb begin
    adj_c = acc_i;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (acc_i[4*i +: 4] >= 4'd5) begin
        adj_c[4*i +: 4] = acc_i[4*i +: 4] + 4'd3;
      end
    end
  end

  assign acc_o   = {adj_c[4*DIGITS-2:0], bit_i};
  assign carry_o = adj_c[4*DIGITS-1];

endmodule

// File: rtl/bin2bcd_len.sv
// Sequential signed binary to BCD converter with decimal length and overflow.
// Converts |in_num| one bit per clock, then reports digits, sign, length.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   in_valid/in_ready     : operand handshake, in_num is the signed operand
//   out_valid/out_ready   : result handshake
//   out_bcd               : packed BCD digits, digit 0 least significant
//   out_length            : decimal digits of |in_num| (DIGITS on overflow)
//   out_neg, out_overflow : operand sign, result exceeds DIGITS digits
module bin2bcd_len
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH    = 22,
  parameter int unsigned DIGITS   = 7,
  parameter bit          BLANK_LZ = 1'b0,
  localparam int unsigned LW      = calc_lw(DIGITS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_num,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] out_bcd,
  output logic [LW-1:0]       out_length,
  output logic                out_neg,
  output logic                out_overflow
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned BW = 4 * DIGITS;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  mag_q, mag_d;
  logic [BW-1:0]     acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic              neg_q, neg_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [BW-1:0]     out_bcd_q, out_bcd_d;
  logic [LW-1:0]     out_length_q, out_length_d;
  logic              out_neg_q, out_neg_d;
  logic              out_overflow_q, out_overflow_d;

  logic [BW-1:0]     step_acc_c;
  logic              step_carry_c;
  logic [WIDTH-1:0]  abs_c;
  logic [LW-1:0]     len_c;
  logic [BW-1:0]     bcd_c;

  bcd_dabble_step #(
    .DIGITS (DIGITS)
  ) u_step (
    .acc_i   (acc_q),
    .bit_i   (mag_q[WIDTH-1]),
    .acc_o   (step_acc_c),
    .carry_o (step_carry_c)
  );

  // Unsigned magnitude; the most negative operand maps to 2^(WIDTH-1).
  assign abs_c = in_num[WIDTH-1] ? (~in_num + WIDTH'(1)) : in_num;

  // Length from the highest nonzero digit, then optional leading-zero blanking.
  always_comb begin
    len_c = LW'(1);
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] != 4'd0) len_c = LW'(i + 1);
    end
    if (ovf_q) len_c = LW'(DIGITS);
    bcd_c = acc_q;
    if (BLANK_LZ) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (LW'(i) >= len_c) bcd_c[4*i +: 4] = DIGIT_BLANK;
      end
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d        = state_q;
    mag_d          = mag_q;
    acc_d          = acc_q;
    ovf_d          = ovf_q;
    neg_d          = neg_q;
    cnt_d          = cnt_q;
    out_valid_d    = out_valid_q;
    out_bcd_d      = out_bcd_q;
    out_length_d   = out_length_q;
    out_neg_d      = out_neg_q;
    out_overflow_d = out_overflow_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          mag_d   = abs_c;
          neg_d   = in_num[WIDTH-1];
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        acc_d = step_acc_c;
        mag_d = {mag_q[WIDTH-2:0], 1'b0};
        ovf_d = ovf_q | step_carry_c;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = ST_FINISH;
      end
      ST_FINISH: begin
        out_bcd_d      = bcd_c;
        out_length_d   = len_c;
        out_neg_d      = neg_q;
        out_overflow_d = ovf_q;
        out_valid_d    = 1'b1;
        state_d        = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      mag_q          <= '0;
      acc_q          <= '0;
      ovf_q          <= 1'b0;
      neg_q          <= 1'b0;
      cnt_q          <= '0;
      out_valid_q    <= 1'b0;
      out_bcd_q      <= '0;
      out_length_q   <= '0;
      out_neg_q      <= 1'b0;
      out_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      mag_q          <= mag_d;
      acc_q          <= acc_d;
      ovf_q          <= ovf_d;
      neg_q          <= neg_d;
      cnt_q          <= cnt_d;
      out_valid_q    <= out_valid_d;
      out_bcd_q      <= out_bcd_d;
      out_length_q   <= out_length_d;
      out_neg_q      <= out_neg_d;
      out_overflow_q <= out_overflow_d;
    end
  end

  assign in_ready     = (state_q == ST_IDLE) && !reset;
  assign out_valid    = out_valid_q;
  assign out_bcd      = out_bcd_q;
  assign out_length   = out_length_q;
  assign out_neg      = out_neg_q;
  assign out_overflow = out_overflow_q;

endmodule

// File: tb/tb_bin2bcd_len.sv
// Scoreboard bench: two converters (7 digits unblanked, 4 digits blanked)
// share one stimulus stream; expected results come from a decimal model.
module tb_bin2bcd_len;

  typedef struct {
    logic [27:0] bcd;
    logic [2:0]  len;
    logic        neg;
    logic        ovf;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [21:0] in_num = '0;
  logic        out_ready = 1'b0;
  logic        in_ready1, in_ready2;
  logic        v1, v2;
  logic [27:0] bcd1;
  logic [15:0] bcd2;
  logic [2:0]  len1, len2;
  logic        neg1, neg2, ovf1, ovf2;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rise1 = 0, rise2 = 0;
  logic v1_prev = 1'b0, v2_prev = 1'b0;
  bit rand_rdy = 1'b0;
  bit rdy_force = 1'b0;
  exp_t q1[$];
  exp_t q2[$];
  exp_t e;

  bin2bcd_len #(.WIDTH(22), .DIGITS(7), .BLANK_LZ(1'b0)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .in_num(in_num), .out_valid(v1), .out_ready(out_ready), .out_bcd(bcd1),
    .out_length(len1), .out_neg(neg1), .out_overflow(ovf1)
  );

  bin2bcd_len #(.WIDTH(22), .DIGITS(4), .BLANK_LZ(1'b1)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .in_num(in_num), .out_valid(v2), .out_ready(out_ready), .out_bcd(bcd2),
    .out_length(len2), .out_neg(neg2), .out_overflow(ovf2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Sole driver of out_ready: forced level or random backpressure.
  always @(posedge clk) begin
    #2;
    out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_force;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Decimal reference: magnitude, modulo 10^d, digit count, blanking.
  function automatic exp_t model(input longint num, input int d, input bit blank);
    exp_t r;
    longint mag, p, m, t;
    int len;
    mag = (num < 0) ? -num : num;
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    r.ovf = (mag >= p);
    r.neg = (num < 0);
    m = mag % p;
    len = 1;
    t = mag / 10;
    while (t > 0) begin
      len++;
      t = t / 10;
    end
    if (r.ovf) len = d;
    r.len = 3'(len);
    r.bcd = '0;
    for (int i = 0; i < d; i++) begin
      r.bcd[4*i +: 4] = (blank && i >= len) ? 4'hF : 4'(m % 10);
      m = m / 10;
    end
    r.cyc = 0;
    return r;
  endfunction

  // Scoreboard push on accept, pop and compare on each output handshake.
  always @(negedge clk) begin
    if (reset) begin
      q1.delete();
      q2.delete();
    end else begin
      if (in_valid && in_ready1) begin
        e = model(longint'($signed(in_num)), 7, 1'b0);
        e.cyc = cyc + 1;
        q1.push_back(e);
        e = model(longint'($signed(in_num)), 4, 1'b1);
        e.cyc = cyc + 1;
        q2.push_back(e);
      end
      if (v1 && !v1_prev) rise1 = cyc;
      if (v2 && !v2_prev) rise2 = cyc;
      if (v1 && out_ready) begin
        if (q1.size() == 0) begin
          tests++; fails++;
          $display("FAIL dut1 unexpected output bcd=%0h", bcd1);
        end else begin
          e = q1.pop_front();
          chk("dut1 bcd", 32'(bcd1), 32'(e.bcd));
          chk("dut1 length", 32'(len1), 32'(e.len));
          chk("dut1 neg", 32'(neg1), 32'(e.neg));
          chk("dut1 overflow", 32'(ovf1), 32'(e.ovf));
          chk("dut1 latency", 32'(rise1 - e.cyc), 32'd23);
        end
      end
      if (v2 && out_ready) begin
        if (q2.size() == 0) begin
          tests++; fails++;
          $display("FAIL dut2 unexpected output bcd=%0h", bcd2);
        end else begin
          e = q2.pop_front();
          chk("dut2 bcd", 32'(bcd2), 32'(e.bcd[15:0]));
          chk("dut2 length", 32'(len2), 32'(e.len));
          chk("dut2 neg", 32'(neg2), 32'(e.neg));
          chk("dut2 overflow", 32'(ovf2), 32'(e.ovf));
          chk("dut2 latency", 32'(rise2 - e.cyc), 32'd23);
        end
      end
    end
    v1_prev = v1;
    v2_prev = v2;
  end

  task automatic send(input logic [21:0] num);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_num = num;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready1) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (!ok) begin
      tests++; fails++;
      $display("FAIL send timeout operand=%0h", num);
    end
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (q1.size() == 0 && q2.size() == 0 && !v1 && !v2) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL drain timeout q1=%0d q2=%0d", q1.size(), q2.size());
    end
  endtask

  task automatic chk_zero_out(input string name);
    chk({name, " out_valid"}, 32'({v1, v2}), 32'd0);
    chk({name, " bcd"}, 32'(bcd1) | 32'(bcd2), 32'd0);
    chk({name, " length"}, 32'({len1, len2}), 32'd0);
    chk({name, " neg/ovf"}, 32'({neg1, neg2, ovf1, ovf2}), 32'd0);
  endtask

  initial begin
    logic [21:0] r;
    // Reset state and in_ready around reset release.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("in_ready during reset", 32'({in_ready1, in_ready2}), 32'd0);
    chk_zero_out("reset");
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("in_ready after reset", 32'({in_ready1, in_ready2}), 32'd3);

    // Directed values, back to back with ready held high.
    rdy_force = 1'b1;
    send(22'd12345);
    send(-22'sd2097152);
    send(22'd2097151);
    send(22'd0);
    send(-22'sd12345);
    send(22'd9999);
    send(22'd10000);
    send(22'd1);
    send(-22'sd1);
    wait_idle();

    // Random operands with random backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      r = 22'($urandom);
      if (i % 3 == 0) r = 22'($urandom_range(0, 20000));
      if (i % 5 == 0) r = -r;
      send(r);
    end
    rand_rdy = 1'b0;
    wait_idle();

    // Backpressure: result held, no accept, then release.
    rdy_force = 1'b0;
    @(posedge clk);
    #1;
    send(22'd555);
    for (int i = 0; i < 40 && !v1; i++) @(negedge clk);
    in_valid = 1'b1;
    in_num = 22'd777;
    repeat (10) begin
      @(negedge clk);
      chk("hold out_valid", 32'({v1, v2}), 32'd3);
      chk("hold bcd1", 32'(bcd1), 32'h555);
      chk("hold bcd2", 32'(bcd2), 32'hF555);
      chk("hold in_ready", 32'({in_ready1, in_ready2}), 32'd0);
    end
    @(posedge clk);
    #1 rdy_force = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("idle after release", 32'({in_ready1, in_ready2}), 32'd3);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_idle();

    // Reset in the middle of a conversion.
    send(22'd123456);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("in_ready mid reset", 32'({in_ready1, in_ready2}), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("in_ready after abort", 32'({in_ready1, in_ready2}), 32'd3);
    chk_zero_out("abort");
    send(22'd99);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog.
  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
